// File: rtl/pipe_reg_hs.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// optional skid buffer (compile with PIPE_REG_SKID_EN for the 2-entry variant).
module pipe_reg_hs #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

`ifdef PIPE_REG_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

    state_t           r_state, w_state_nx;
    logic             r_main_v, r_skid_v, r_in_ready;
    logic [WIDTH-1:0] r_main_d, r_skid_d;
    logic             w_main_v_nx, w_skid_v_nx;
    logic [WIDTH-1:0] w_main_d_nx, w_skid_d_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_EMPTY;
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_main_d   <= RESET_VAL;
            r_skid_d   <= RESET_VAL;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_main_v   <= w_main_v_nx;
            r_skid_v   <= w_skid_v_nx;
            r_main_d   <= w_main_d_nx;
            r_skid_d   <= w_skid_d_nx;
            // Registered so in_ready never sees out_ready combinationally.
            r_in_ready <= (w_state_nx != S_SKID);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_main_v_nx = r_main_v;
        w_skid_v_nx = r_skid_v;
        w_main_d_nx = r_main_d;
        w_skid_d_nx = r_skid_d;
        if (flush) begin
            w_state_nx  = S_EMPTY;
            w_main_v_nx = 1'b0;
            w_skid_v_nx = 1'b0;
            w_main_d_nx = RESET_VAL;
            w_skid_d_nx = RESET_VAL;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (in_valid) begin
                        w_state_nx  = S_FULL;
                        w_main_v_nx = 1'b1;
                        w_main_d_nx = in_data;
                    end
                end
                S_FULL: begin
                    if (in_valid && out_ready) begin
                        w_main_d_nx = in_data;
                    end else if (in_valid) begin
                        w_state_nx  = S_SKID;
                        w_skid_v_nx = 1'b1;
                        w_skid_d_nx = in_data;
                    end else if (out_ready) begin
                        w_state_nx  = S_EMPTY;
                        w_main_v_nx = 1'b0;
                    end
                end
                S_SKID: begin
                    if (out_ready) begin
                        w_state_nx  = S_FULL;
                        w_skid_v_nx = 1'b0;
                        w_main_d_nx = r_skid_d;
                    end
                end
                default: begin
                    w_state_nx  = S_EMPTY;
                    w_main_v_nx = 1'b0;
                    w_skid_v_nx = 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_v;
    assign out_data  = r_main_d;
    assign level     = {1'b0, r_main_v} + {1'b0, r_skid_v};
`else
    logic             r_main_v;
    logic [WIDTH-1:0] r_main_d;
    logic             w_in_ready;

    assign w_in_ready = !r_main_v || out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main_v <= 1'b0;
            r_main_d <= RESET_VAL;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_main_d <= RESET_VAL;
        end else if (in_valid && w_in_ready) begin
            r_main_v <= 1'b1;
            r_main_d <= in_data;
        end else if (out_ready) begin
            // Drain keeps the stale payload; only the valid bit drops.
            r_main_v <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_v;
    assign out_data  = r_main_d;
    assign level     = {1'b0, r_main_v};
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed and randomized self-checking bench for pipe_reg_hs (base or skid build).
module tb_pipe_reg_hs;

`ifdef PIPE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  level;

    int checks = 0;
    int errors = 0;

    pipe_reg_hs #(.WIDTH(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic ev, input logic [31:0] ed,
                           input logic [1:0] el);
        checks++;
        if (out_valid !== ev || out_data !== ed || level !== el) begin
            errors++;
            $display("FAIL %s: got v=%b d=%h lvl=%0d, expected v=%b d=%h lvl=%0d",
                     name, out_valid, out_data, level, ev, ed, el);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0; flush = 1'b0;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("reset_hold", 1'b0, 32'h0, 2'd0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            end
        end
        resetn = 1'b1;
        step();
        chk_out("reset_first_beat", 1'b1, 32'hDEADBEEF, 2'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk_out("reset_drain", 1'b0, 32'hDEADBEEF, 2'd0);
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
            chk_out($sformatf("stream_%0d", i), 1'b1, i, 2'd1);
        end
        in_valid = 1'b0;
        step();
        chk_out("stream_drain", 1'b0, 32'd8, 2'd0);
    endtask

    task automatic test_stall();
        logic       exp_rdy;
        logic [1:0] exp_lvl;
        in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
        step();
        chk_out("stall_load_a", 1'b1, 32'hA, 2'd1);
        in_data = 32'hB;
        #1;
        exp_rdy = SKID;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL stall_ready_pre: got %b expected %b", in_ready, exp_rdy);
        end
        exp_lvl = SKID ? 2'd2 : 2'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("stall_hold_a", 1'b1, 32'hA, exp_lvl);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready: got %b expected 0", in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_out("stall_release_b", 1'b1, 32'hB, 2'd1);
        step();
        chk_out("stall_empty", 1'b0, 32'hB, 2'd0);
    endtask

    task automatic fill();
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
        step();
        in_data = 32'h22;
        step();
        in_valid = 1'b0;
        chk_out("fill", 1'b1, 32'h11, SKID ? 2'd2 : 2'd1);
    endtask

    task automatic test_flush();
        fill();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_out("flush_clear", 1'b0, 32'h0, 2'd0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready: got %b expected 1", in_ready);
        end
        step();
        chk_out("flush_no_c", 1'b0, 32'h0, 2'd0);
    endtask

    task automatic test_async_reset();
        fill();
        #3 resetn = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 32'h0, 2'd0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_ready: got %b expected 1", in_ready);
        end
        step();
        resetn = 1'b1;
        chk_out("async_reset_hold", 1'b0, 32'h0, 2'd0);
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp;
        logic        rdy_snap;
        for (int cyc = 0; cyc < 10004; cyc++) begin
            if (cyc < 10000) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = $urandom;
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
`ifdef PIPE_REG_SKID_EN
            #1;
            rdy_snap  = in_ready;
            out_ready = ~out_ready;
            #1;
            checks++;
            if (in_ready !== rdy_snap) begin
                errors++;
                $display("FAIL ready_comb_path: got %b expected %b", in_ready, rdy_snap);
            end
            out_ready = ~out_ready;
`else
            rdy_snap = 1'b0;
`endif
            @(negedge clk);
            if (out_valid && out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
                checks++;
                if (out_data !== exp) begin
                    errors++;
                    $display("FAIL random_data cyc %0d: got %h expected %h", cyc, out_data, exp);
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            step();
        end
        checks++;
        if (q.size() != 0 || rdy_snap === 1'bz) begin
            errors++;
            $display("FAIL random_lost: %0d beats left, expected 0", q.size());
        end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
